// File: rtl/comb_filter_prog.sv
// ---------------------------------------------------------------------------
// comb_filter_prog -- programmable I/Q comb filter (feedforward / feedback)
//
// Purpose:
//   Strobe-qualified comb filter for an I/Q sample stream, intended to sit
//   behind a decimator. The delay length and mode are programmable at run
//   time. Any change to either one flushes the history, so samples taken
//   under the old configuration never reach the output.
//
//   Feedforward : y = x - x[n-D]
//   Feedback    : y = x - h + (h >>> S), and y is stored back as h
//   The output is the internal sum with the GUARD bits floored away.
//
// Ports (top):
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   strobe_in   in   input sample valid (one-cycle pulses, back-to-back ok)
//   i_in/q_in   in   BIT_WIDTH two's-complement samples
//   delay_m1    in   comb delay minus one, D = delay_m1 + 1 (shadowed)
//   fb_shift    in   feedback attenuation shift S, 0..31 (not shadowed)
//   mode_fb     in   0 = feedforward, 1 = feedback (shadowed)
//   busy        out  history flush in progress; strobes are dropped
//   strobe_out  out  result valid, exactly one clock after strobe_in
//   i_out/q_out out  BIT_WIDTH results, held between strobes
//
// Build option:
//   COMB_FILTER_SAT_EN  defined   -> reduction to IW saturates
//                       undefined -> reduction to IW wraps
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// comb_filter_chan -- one channel (lane): history RAM, datapath, output reg
//
// Ports:
//   clock, reset     clock / sync active-high reset (output register only)
//   flush_i          write zero to flush_addr_i this cycle
//   flush_addr_i     history address being cleared
//   run_stb_i        accepted sample this cycle
//   ptr_i            history read/write pointer
//   mode_fb_i        feedback mode (shadowed copy)
//   fb_shift_i       feedback attenuation shift
//   x_i              input sample
//   y_o              registered output sample
// ---------------------------------------------------------------------------
module comb_filter_chan #(
  parameter int BIT_WIDTH      = 16,
  parameter int GUARD          = 3,
  parameter int MAX_DELAY_LOG2 = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [MAX_DELAY_LOG2-1:0] flush_addr_i,
  input  logic                      run_stb_i,
  input  logic [MAX_DELAY_LOG2-1:0] ptr_i,
  input  logic                      mode_fb_i,
  input  logic [4:0]                fb_shift_i,
  input  logic [BIT_WIDTH-1:0]      x_i,
  output logic [BIT_WIDTH-1:0]      y_o
);
  localparam int IW    = BIT_WIDTH + GUARD;
  localparam int AW    = IW + 2;
  localparam int DEPTH = 1 << MAX_DELAY_LOG2;

  // History has no reset: the FSM always flushes it after reset.
  logic        [IW-1:0]        hist_q [DEPTH];
  logic        [BIT_WIDTH-1:0] y_q, y_d;

  logic signed [IW-1:0] x_e, h, h_sh, sum_r, store;
  logic        [AW-1:0] sum_w, fb_term;

  always_comb begin
    x_e  = {{GUARD{x_i[BIT_WIDTH-1]}}, x_i};
    h    = hist_q[ptr_i];
    // Signed >>> fills with the sign once S reaches IW or more.
    h_sh = h >>> fb_shift_i;
    fb_term = mode_fb_i ? {{2{h_sh[IW-1]}}, h_sh} : '0;
    // Two extra bits are enough: |x - h + h>>>S| < 2^(IW+1).
    sum_w = {{2{x_e[IW-1]}}, x_e} - {{2{h[IW-1]}}, h} + fb_term;
  end

`ifdef COMB_FILTER_SAT_EN
  // Overflow when the top three bits disagree; clamp toward the sign.
  always_comb begin
    sum_r = sum_w[IW-1:0];
    if (!((sum_w[AW-1:IW-1] == 3'b000) || (sum_w[AW-1:IW-1] == 3'b111)))
      sum_r = sum_w[AW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_w[AW-1:IW];
  always_comb sum_r = sum_w[IW-1:0];
`endif

  always_comb begin
    store = mode_fb_i ? sum_r : x_e;
    // Dropping GUARD LSBs of a two's-complement value is a floor divide.
    y_d   = sum_r[IW-1:GUARD];
  end

  always_ff @(posedge clock) begin
    if (flush_i)
      hist_q[flush_addr_i] <= '0;
    else if (run_stb_i)
      hist_q[ptr_i] <= store;
  end

  always_ff @(posedge clock) begin
    if (reset)          y_q <= '0;
    else if (run_stb_i) y_q <= y_d;
  end

  assign y_o = y_q;
endmodule

// ---------------------------------------------------------------------------
// comb_filter_prog -- top: config shadowing, flush FSM, two channel lanes
// ---------------------------------------------------------------------------
module comb_filter_prog #(
  parameter int BIT_WIDTH      = 16,
  parameter int GUARD          = 3,
  parameter int MAX_DELAY_LOG2 = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      strobe_in,
  input  logic [BIT_WIDTH-1:0]      i_in,
  input  logic [BIT_WIDTH-1:0]      q_in,
  input  logic [MAX_DELAY_LOG2-1:0] delay_m1,
  input  logic [4:0]                fb_shift,
  input  logic                      mode_fb,
  output logic                      busy,
  output logic                      strobe_out,
  output logic [BIT_WIDTH-1:0]      i_out,
  output logic [BIT_WIDTH-1:0]      q_out
);
  localparam int NUM_LANES = 2;  // lane 0 = I, lane 1 = Q

  typedef enum logic {FLUSH, RUN} state_t;

  state_t                    state_q, state_d;
  logic [MAX_DELAY_LOG2-1:0] flush_addr_q, flush_addr_d;
  logic [MAX_DELAY_LOG2-1:0] hist_ptr_q, hist_ptr_d;
  logic [MAX_DELAY_LOG2-1:0] dly_sh_q, dly_sh_d;
  logic                      mode_sh_q, mode_sh_d;
  logic                      stb_out_q;
  logic                      run_stb, flush;

  logic [NUM_LANES-1:0][BIT_WIDTH-1:0] x_lane, y_lane;

  // Next-state: FLUSH walks every history address once, then RUN.
  always_comb begin
    state_d      = state_q;
    flush_addr_d = flush_addr_q;
    hist_ptr_d   = hist_ptr_q;
    dly_sh_d     = dly_sh_q;
    mode_sh_d    = mode_sh_q;
    run_stb      = 1'b0;
    flush        = 1'b0;
    case (state_q)
      FLUSH: begin
        flush        = 1'b1;
        flush_addr_d = flush_addr_q + 1'b1;
        if (flush_addr_q == '1) begin
          state_d    = RUN;
          hist_ptr_d = '0;
        end
      end
      RUN: begin
        // A strobe coinciding with a config change is still processed
        // under the old shadow settings; the flush then wipes it.
        run_stb = strobe_in;
        if (strobe_in)
          hist_ptr_d = (hist_ptr_q == dly_sh_q) ? '0 : hist_ptr_q + 1'b1;
        if ((delay_m1 != dly_sh_q) || (mode_fb != mode_sh_q)) begin
          dly_sh_d     = delay_m1;
          mode_sh_d    = mode_fb;
          state_d      = FLUSH;
          flush_addr_d = '0;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FLUSH;
      flush_addr_q <= '0;
      hist_ptr_q   <= '0;
      dly_sh_q     <= delay_m1;
      mode_sh_q    <= mode_fb;
      stb_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_addr_q <= flush_addr_d;
      hist_ptr_q   <= hist_ptr_d;
      dly_sh_q     <= dly_sh_d;
      mode_sh_q    <= mode_sh_d;
      stb_out_q    <= run_stb;
    end
  end

  assign x_lane[0] = i_in;
  assign x_lane[1] = q_in;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    comb_filter_chan #(
      .BIT_WIDTH      (BIT_WIDTH),
      .GUARD          (GUARD),
      .MAX_DELAY_LOG2 (MAX_DELAY_LOG2)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .flush_i      (flush & ~reset),
      .flush_addr_i (flush_addr_q),
      .run_stb_i    (run_stb & ~reset),
      .ptr_i        (hist_ptr_q),
      .mode_fb_i    (mode_sh_q),
      .fb_shift_i   (fb_shift),
      .x_i          (x_lane[l]),
      .y_o          (y_lane[l])
    );
  end

  assign busy       = (state_q == FLUSH);
  assign strobe_out = stb_out_q;
  assign i_out      = y_lane[0];
  assign q_out      = y_lane[1];
endmodule

// File: tb/tb_comb_filter_prog.sv
// ---------------------------------------------------------------------------
// tb_comb_filter_prog -- scoreboard bench for comb_filter_prog
// Stimulus pushes hand-computed expected results; a negedge monitor pops
// them whenever strobe_out is seen, and checks hold/reset values otherwise.
// ---------------------------------------------------------------------------
module tb_comb_filter_prog;
  localparam int BW = 16;
  localparam int ML = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          strobe_in = 1'b0;
  logic [BW-1:0] i_in = '0;
  logic [BW-1:0] q_in = '0;
  logic [ML-1:0] delay_m1 = 3'd3;
  logic [4:0]    fb_shift = 5'd0;
  logic          mode_fb = 1'b0;
  logic          busy, strobe_out;
  logic [BW-1:0] i_out, q_out;

  always #5 clock = ~clock;

  comb_filter_prog dut (
    .clock      (clock),
    .reset      (reset),
    .strobe_in  (strobe_in),
    .i_in       (i_in),
    .q_in       (q_in),
    .delay_m1   (delay_m1),
    .fb_shift   (fb_shift),
    .mode_fb    (mode_fb),
    .busy       (busy),
    .strobe_out (strobe_out),
    .i_out      (i_out),
    .q_out      (q_out)
  );

  typedef struct { int i; int q; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int nout   = 0;

  int ff_i [10] = '{125, 0, 0, 0, -125, 0, 0, 0, 0, 0};
`ifdef COMB_FILTER_SAT_EN
  int alt_i [11] = '{4095, -8160, 12192, -16193, 20162, -24101, 28008, -31886,
                     32767, -32768, 32767};
`else
  int alt_i [11] = '{4095, -8160, 12192, -16193, 20162, -24101, 28008, -31886,
                     -29804, 25475, -21181};
`endif

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor
  bit rst_d = 1'b0;
  bit armed = 1'b0;
  int li = 0, lq = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rst_d) begin
        chk("rst_strobe_out", strobe_out, 0);
        chk("rst_i_out", $signed(i_out), 0);
        chk("rst_q_out", $signed(q_out), 0);
        li = 0; lq = 0; armed = 1'b1;
      end else if (armed) begin
        if (strobe_out === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out i=%0d q=%0d", $signed(i_out), $signed(q_out));
          end else begin
            e = sb.pop_front();
            chk($sformatf("out%0d_i", nout), $signed(i_out), e.i);
            chk($sformatf("out%0d_q", nout), $signed(q_out), e.q);
          end
          nout++;
          li = $signed(i_out); lq = $signed(q_out);
        end else begin
          chk("idle_strobe_out", strobe_out, 0);
          chk("hold_i", $signed(i_out), li);
          chk("hold_q", $signed(q_out), lq);
        end
      end
      rst_d = reset;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic strobe(input int xi, input int xq, input int ei, input int eq);
    exp_t e;
    e.i = ei; e.q = eq;
    sb.push_back(e);
    strobe_in = 1'b1; i_in = BW'(xi); q_in = BW'(xq);
    tick();
    strobe_in = 1'b0; i_in = '0; q_in = '0;
  endtask

  // Eight flush cycles with busy high; strobes injected here must vanish.
  task automatic busy_window(input string nm, input int drop_at);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_busy%0d", nm, k), busy, 1);
      strobe_in = (k == drop_at) || (k == drop_at + 3);
      i_in = 16'd4000; q_in = 16'd4000;
      tick();
      strobe_in = 1'b0; i_in = '0; q_in = '0;
    end
    chk($sformatf("%s_done", nm), busy, 0);
  endtask

  task automatic set_cfg(input int d, input bit m, input int s);
    delay_m1 = ML'(d); mode_fb = m; fb_shift = 5'(s);
    tick();
    for (int k = 0; k < 20 && busy; k++) tick();
    chk("cfg_idle", busy, 0);
  endtask

  initial begin
    // Reset then flush; stray strobe at flush cycle 3
    reset = 1'b1; delay_m1 = 3'd3; mode_fb = 1'b0; fb_shift = 5'd0;
    tick(); tick();
    reset = 1'b0;
    busy_window("rst", 3);

    // Feedforward D=4, strobe every cycle
    for (int n = 0; n < 10; n++) strobe(n == 0 ? 1000 : 0, 0, ff_i[n], 0);

    // Feedback D=8 S=3
    set_cfg(7, 1'b1, 3);
    for (int n = 0; n < 20; n++)
      strobe(n == 0 ? 8000 : 0, 0,
             n == 0 ? 1000 : n == 8 ? -875 : n == 16 ? 765 : 0, 0);

    // Reset mid-stream, with a strobe in the reset cycle
    strobe(5000, 0, 625, 0);
    reset = 1'b1; strobe_in = 1'b1; i_in = 16'd3000;
    mode_fb = 1'b0; delay_m1 = 3'd3; fb_shift = 5'd0;
    tick();
    strobe_in = 1'b0; i_in = '0;
    tick();
    reset = 1'b0;
    busy_window("rst2", 1);

    // Feedforward D=4, strobe every 3rd cycle
    for (int n = 0; n < 10; n++) begin
      strobe(n == 0 ? 1000 : 0, 0, ff_i[n], 0);
      tick(); tick();
    end

    // Mid-stream delay change 3 -> 1, strobe in the change cycle
    strobe(1000, 0, 125, 0);
    strobe(0, 0, 0, 0);
    delay_m1 = 3'd1;
    strobe(0, 0, 0, 0);
    busy_window("dly", 2);
    strobe(800, -800, 100, -100);
    strobe(0, 0, 0, 0);
    strobe(0, 0, -100, 100);
    strobe(0, 0, 0, 0);

    // Feedback D=1 S=7, full-scale alternating input
    set_cfg(0, 1'b1, 7);
    for (int n = 0; n < 11; n++)
      strobe((n % 2 == 0) ? 32767 : -32768, 0, alt_i[n], 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("drain", sb.size(), 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
